// File: rtl/axil_req_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite style request port among NUM_REQ requesters.
// Optional BUSY watchdog enabled by defining AXIL_ARB_TIMEOUT_EN.
module axil_req_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  input  logic [NUM_REQ-1:0]                  req_write_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]       req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_wdata_i,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]   req_wstrb_i,
  output logic [NUM_REQ-1:0]                  rsp_ready_o,
  output logic [DATA_WIDTH-1:0]               rsp_rdata_o,
  output logic                                rsp_error_o,
  output logic                                m_valid_o,
  output logic                                m_write_o,
  output logic [ADDR_WIDTH-1:0]               m_addr_o,
  output logic [DATA_WIDTH-1:0]               m_wdata_o,
  output logic [DATA_WIDTH/8-1:0]             m_wstrb_o,
  input  logic                                m_ready_i,
  input  logic [DATA_WIDTH-1:0]               m_rdata_i,
  input  logic                                m_error_i,
  output logic                                busy_o,
  output logic                                timeout_o
);

  localparam int unsigned SW    = DATA_WIDTH / 8;
  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]            state, state_n;
  logic [PTR_W-1:0]      ptr, ptr_n;
  logic [PTR_W-1:0]      grant, grant_n;
  logic [PTR_W-1:0]      sel;
  logic                  found;
  logic                  m_valid_n, m_write_n;
  logic [ADDR_WIDTH-1:0] m_addr_n;
  logic [DATA_WIDTH-1:0] m_wdata_n;
  logic [SW-1:0]         m_wstrb_n;
  logic [NUM_REQ-1:0]    rsp_ready_n;
  logic [DATA_WIDTH-1:0] rsp_rdata_n;
  logic                  rsp_error_n;
  logic                  timeout_n;

`ifdef AXIL_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt, cnt_n;
`else
  logic unused_cfg;
  assign unused_cfg = |TIMEOUT_CYCLES;
`endif

  // First valid requester at or above the round-robin pointer, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      logic [PTR_W-1:0] idx;
      idx = PTR_W'((32'(ptr) + i) % NUM_REQ);
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    grant_n     = grant;
    m_valid_n   = m_valid_o;
    m_write_n   = m_write_o;
    m_addr_n    = m_addr_o;
    m_wdata_n   = m_wdata_o;
    m_wstrb_n   = m_wstrb_o;
    rsp_ready_n = '0;
    rsp_rdata_n = '0;
    rsp_error_n = 1'b0;
    timeout_n   = 1'b0;
`ifdef AXIL_ARB_TIMEOUT_EN
    cnt_n       = cnt;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          state_n   = BUSY;
          grant_n   = sel;
          m_valid_n = 1'b1;
          m_write_n = req_write_i[sel];
          m_addr_n  = req_addr_i[32'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
          m_wdata_n = req_wdata_i[32'(sel)*DATA_WIDTH +: DATA_WIDTH];
          m_wstrb_n = req_wstrb_i[32'(sel)*SW +: SW];
`ifdef AXIL_ARB_TIMEOUT_EN
          cnt_n     = '0;
`endif
        end
      end
      BUSY: begin
        if (m_ready_i) begin
          state_n     = RESP;
          m_valid_n   = 1'b0;
          ptr_n       = (32'(grant) == NUM_REQ - 1) ? '0 : grant + PTR_W'(1);
          rsp_ready_n = NUM_REQ'(1) << grant;
          rsp_rdata_n = m_write_o ? '0 : m_rdata_i;
          rsp_error_n = m_error_i;
        end
`ifdef AXIL_ARB_TIMEOUT_EN
        // Watchdog abort: respond with error and move the pointer on.
        else if (32'(cnt) == TIMEOUT_CYCLES - 1) begin
          state_n     = RESP;
          m_valid_n   = 1'b0;
          ptr_n       = (32'(grant) == NUM_REQ - 1) ? '0 : grant + PTR_W'(1);
          rsp_ready_n = NUM_REQ'(1) << grant;
          rsp_error_n = 1'b1;
          timeout_n   = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
`endif
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      ptr         <= '0;
      grant       <= '0;
      m_valid_o   <= 1'b0;
      m_write_o   <= 1'b0;
      m_addr_o    <= '0;
      m_wdata_o   <= '0;
      m_wstrb_o   <= '0;
      rsp_ready_o <= '0;
      rsp_rdata_o <= '0;
      rsp_error_o <= 1'b0;
      busy_o      <= 1'b0;
      timeout_o   <= 1'b0;
`ifdef AXIL_ARB_TIMEOUT_EN
      cnt         <= '0;
`endif
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      grant       <= grant_n;
      m_valid_o   <= m_valid_n;
      m_write_o   <= m_write_n;
      m_addr_o    <= m_addr_n;
      m_wdata_o   <= m_wdata_n;
      m_wstrb_o   <= m_wstrb_n;
      rsp_ready_o <= rsp_ready_n;
      rsp_rdata_o <= rsp_rdata_n;
      rsp_error_o <= rsp_error_n;
      busy_o      <= (state_n != IDLE);
      timeout_o   <= timeout_n;
`ifdef AXIL_ARB_TIMEOUT_EN
      cnt         <= cnt_n;
`endif
    end
  end

endmodule
